// File: rtl/regdst_pipe_if.sv
// Bus between EX-stage control and the destination-register pipeline.
// Carries illegal_err only when REGDST_ILLEGAL_CHK_EN is defined.
interface regdst_pipe_if #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3
);
  localparam int FWD_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]       ins_20_16;
  logic [ADDR_W-1:0]       ins_15_11;
  logic [1:0]              reg_dst;
  logic                    reg_write;
  logic                    in_valid;
  logic                    stall;
  logic                    flush;
  logic [ADDR_W-1:0]       src_a;
  logic [ADDR_W-1:0]       src_b;
  logic [ADDR_W-1:0]       result;
  logic [DEPTH*ADDR_W-1:0] dest_q;
  logic [DEPTH-1:0]        wen_q;
  logic [FWD_W-1:0]        fwd_a;
  logic [FWD_W-1:0]        fwd_b;
`ifdef REGDST_ILLEGAL_CHK_EN
  logic                    illegal_err;
`endif

  modport master (
    output ins_20_16, ins_15_11, reg_dst, reg_write, in_valid, stall, flush,
    output src_a, src_b,
`ifdef REGDST_ILLEGAL_CHK_EN
    input  illegal_err,
`endif
    input  result, dest_q, wen_q, fwd_a, fwd_b
  );

  modport slave (
    input  ins_20_16, ins_15_11, reg_dst, reg_write, in_valid, stall, flush,
    input  src_a, src_b,
`ifdef REGDST_ILLEGAL_CHK_EN
    output illegal_err,
`endif
    output result, dest_q, wen_q, fwd_a, fwd_b
  );
endinterface

// File: rtl/regdst_pipe.sv
// Destination-register select, DEPTH-stage in-flight tracking and forwarding resolution.
// Optional reserved-encoding trap: define REGDST_ILLEGAL_CHK_EN.
module regdst_pipe #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = 31
) (
  input logic          clk,
  input logic          rst_n,
  regdst_pipe_if.slave bus
);
  localparam int FWD_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  logic [ADDR_W-1:0] result_next;
  logic              eff_next;
  logic              reserved_sel;
  logic [ADDR_W-1:0] dest_reg [DEPTH];
  logic              wen_reg  [DEPTH];
  logic [FWD_W-1:0]  fwd_a_next;
  logic [FWD_W-1:0]  fwd_b_next;

  always_comb begin
    result_next = bus.ins_20_16;
    case (bus.reg_dst)
      2'b01:   result_next = bus.ins_15_11;
      2'b10:   result_next = LINK_ADDR;
      default: result_next = bus.ins_20_16;
    endcase
  end

  assign reserved_sel = (bus.reg_dst == 2'b11);

`ifdef REGDST_ILLEGAL_CHK_EN
  logic illegal_err_reg;

  // Reserved encodings are trapped and retired as bubbles.
  assign eff_next = bus.reg_write & bus.in_valid & (result_next != '0) & ~reserved_sel;

  always_ff @(posedge clk) begin
    if (!rst_n)
      illegal_err_reg <= 1'b0;
    else if (bus.in_valid && reserved_sel && !bus.stall && !bus.flush)
      illegal_err_reg <= 1'b1;
  end

  assign bus.illegal_err = illegal_err_reg;
`else
  logic unused_reserved;
  assign unused_reserved = reserved_sel;
  assign eff_next = bus.reg_write & bus.in_valid & (result_next != '0);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        // Flush overrides stall for the youngest slot only.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            dest_reg[0] <= '0;
            wen_reg[0]  <= 1'b0;
          end else if (bus.flush) begin
            dest_reg[0] <= '0;
            wen_reg[0]  <= 1'b0;
          end else if (!bus.stall) begin
            dest_reg[0] <= result_next;
            wen_reg[0]  <= eff_next;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            dest_reg[gi] <= '0;
            wen_reg[gi]  <= 1'b0;
          end else if (!bus.stall) begin
            dest_reg[gi] <= dest_reg[gi-1];
            wen_reg[gi]  <= wen_reg[gi-1];
          end
        end
      end

      assign bus.dest_q[gi*ADDR_W +: ADDR_W] = dest_reg[gi];
      assign bus.wen_q[gi]                   = wen_reg[gi];
    end
  endgenerate

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fwd_a_next = '0;
    fwd_b_next = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (wen_reg[k] && dest_reg[k] == bus.src_a)
        fwd_a_next = FWD_W'(k + 1);
      if (wen_reg[k] && dest_reg[k] == bus.src_b)
        fwd_b_next = FWD_W'(k + 1);
    end
    if (bus.src_a == '0)
      fwd_a_next = '0;
    if (bus.src_b == '0)
      fwd_b_next = '0;
  end

  assign bus.result = result_next;
  assign bus.fwd_a  = fwd_a_next;
  assign bus.fwd_b  = fwd_b_next;
endmodule

// File: tb/tb_regdst_pipe.sv
// Directed bench for regdst_pipe at default parameters (ADDR_W 5, DEPTH 3, LINK_REG 31).
module tb_regdst_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  regdst_pipe_if #(.ADDR_W(5), .DEPTH(3)) bus ();

  regdst_pipe #(.ADDR_W(5), .DEPTH(3), .LINK_REG(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.reg_dst   = 2'b01;
    bus.ins_15_11 = rd;
    bus.reg_write = 1'b1;
    bus.in_valid  = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.ins_20_16 = 5'd1; bus.ins_15_11 = 5'd2; bus.reg_dst = 2'b00;
    bus.reg_write = 1'b1; bus.in_valid = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.src_a = 5'd1; bus.src_b = 5'd2;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (bus.wen_q !== 3'b000) begin errors++; $display("FAIL reset_wen got %b expected %b", bus.wen_q, 3'b000); end
    checks++; if (bus.dest_q !== 15'd0) begin errors++; $display("FAIL reset_dest got %h expected %h", bus.dest_q, 15'd0); end
    checks++; if (bus.fwd_a !== 2'd0 || bus.fwd_b !== 2'd0) begin errors++; $display("FAIL reset_fwd got %0d/%0d expected 0/0", bus.fwd_a, bus.fwd_b); end
    $display("reset: wen_q=%b dest_q=%h", bus.wen_q, bus.dest_q);
  endtask

  task automatic test_select();
    bus.reg_dst = 2'b00; #1;
    checks++; if (bus.result !== 5'd1) begin errors++; $display("FAIL sel_rt got %0d expected 1", bus.result); end
    bus.reg_dst = 2'b01; #1;
    checks++; if (bus.result !== 5'd2) begin errors++; $display("FAIL sel_rd got %0d expected 2", bus.result); end
    bus.reg_dst = 2'b10; #1;
    checks++; if (bus.result !== 5'd31) begin errors++; $display("FAIL sel_link got %0d expected 31", bus.result); end
    bus.reg_dst = 2'b11; #1;
    checks++; if (bus.result !== 5'd1) begin errors++; $display("FAIL sel_reserved got %0d expected 1", bus.result); end
    $display("select: result checks done, wen_q=%b", bus.wen_q);
  endtask

  task automatic test_shift();
    rst_n = 1'b1;
    issue(5'd5); issue(5'd6); issue(5'd7);
    checks++; if (bus.dest_q !== {5'd5, 5'd6, 5'd7}) begin errors++; $display("FAIL shift_dest got %h expected %h", bus.dest_q, {5'd5, 5'd6, 5'd7}); end
    checks++; if (bus.wen_q !== 3'b111) begin errors++; $display("FAIL shift_wen got %b expected 111", bus.wen_q); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.dest_q[14:10] !== 5'd6 || bus.wen_q !== 3'b110) begin errors++; $display("FAIL shift_idle got st2=%0d wen=%b expected st2=6 wen=110", bus.dest_q[14:10], bus.wen_q); end
    $display("shift: dest_q=%h wen_q=%b", bus.dest_q, bus.wen_q);
  endtask

  task automatic test_forward();
    issue(5'd4); issue(5'd9); issue(5'd9);
    bus.in_valid = 1'b0;
    bus.src_a = 5'd9; bus.src_b = 5'd4; #1;
    checks++; if (bus.fwd_a !== 2'd1) begin errors++; $display("FAIL fwd_young got %0d expected 1", bus.fwd_a); end
    checks++; if (bus.fwd_b !== 2'd3) begin errors++; $display("FAIL fwd_old got %0d expected 3", bus.fwd_b); end
    bus.src_a = 5'd0; bus.src_b = 5'd7; #1;
    checks++; if (bus.fwd_a !== 2'd0) begin errors++; $display("FAIL fwd_zero got %0d expected 0", bus.fwd_a); end
    checks++; if (bus.fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_miss got %0d expected 0", bus.fwd_b); end
    $display("forward: dest_q=%h fwd checks done", bus.dest_q);
  endtask

  task automatic test_zero_bubble();
    issue(5'd0);
    checks++; if (bus.wen_q[0] !== 1'b0) begin errors++; $display("FAIL zero_wen got %b expected 0", bus.wen_q[0]); end
    bus.src_a = 5'd0; #1;
    checks++; if (bus.fwd_a !== 2'd0) begin errors++; $display("FAIL zero_fwd got %0d expected 0", bus.fwd_a); end
    bus.ins_15_11 = 5'd9; bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.wen_q !== 3'b100) begin errors++; $display("FAIL bubble_wen got %b expected 100", bus.wen_q); end
    bus.src_a = 5'd9; #1;
    checks++; if (bus.fwd_a !== 2'd3) begin errors++; $display("FAIL bubble_nomatch got %0d expected 3", bus.fwd_a); end
    $display("zero_bubble: dest_q=%h wen_q=%b", bus.dest_q, bus.wen_q);
  endtask

  task automatic test_stall_flush();
    issue(5'd1); issue(5'd2); issue(5'd3);
    bus.ins_15_11 = 5'd8; bus.stall = 1'b1;
    tick(); tick();
    checks++; if (bus.dest_q !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL stall_dest got %h expected %h", bus.dest_q, {5'd1, 5'd2, 5'd3}); end
    checks++; if (bus.wen_q !== 3'b111) begin errors++; $display("FAIL stall_wen got %b expected 111", bus.wen_q); end
    bus.flush = 1'b1;
    tick();
    checks++; if (bus.dest_q !== {5'd1, 5'd2, 5'd0}) begin errors++; $display("FAIL stallflush_dest got %h expected %h", bus.dest_q, {5'd1, 5'd2, 5'd0}); end
    checks++; if (bus.wen_q !== 3'b110) begin errors++; $display("FAIL stallflush_wen got %b expected 110", bus.wen_q); end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.dest_q !== {5'd2, 5'd0, 5'd0}) begin errors++; $display("FAIL flush_dest got %h expected %h", bus.dest_q, {5'd2, 5'd0, 5'd0}); end
    checks++; if (bus.wen_q !== 3'b100) begin errors++; $display("FAIL flush_wen got %b expected 100", bus.wen_q); end
    bus.flush = 1'b0;
    $display("stall_flush: dest_q=%h wen_q=%b", bus.dest_q, bus.wen_q);
  endtask

  task automatic test_reserved();
    bus.reg_dst = 2'b11; bus.ins_20_16 = 5'd12; bus.ins_15_11 = 5'd13;
    bus.reg_write = 1'b1; bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.dest_q[4:0] !== 5'd12) begin errors++; $display("FAIL reserved_dest got %0d expected 12", bus.dest_q[4:0]); end
`ifdef REGDST_ILLEGAL_CHK_EN
    checks++; if (bus.wen_q[0] !== 1'b0) begin errors++; $display("FAIL illegal_wen got %b expected 0", bus.wen_q[0]); end
    checks++; if (bus.illegal_err !== 1'b1) begin errors++; $display("FAIL illegal_set got %b expected 1", bus.illegal_err); end
    bus.reg_dst = 2'b00;
    tick(); tick();
    checks++; if (bus.illegal_err !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %b expected 1", bus.illegal_err); end
    rst_n = 1'b0;
    tick();
    checks++; if (bus.illegal_err !== 1'b0) begin errors++; $display("FAIL illegal_clear got %b expected 0", bus.illegal_err); end
    rst_n = 1'b1;
`else
    checks++; if (bus.wen_q[0] !== 1'b1) begin errors++; $display("FAIL reserved_wen got %b expected 1", bus.wen_q[0]); end
`endif
    $display("reserved: dest_q=%h wen_q=%b", bus.dest_q, bus.wen_q);
  endtask

  task automatic test_mid_reset();
    issue(5'd20); issue(5'd21);
    rst_n = 1'b0;
    tick();
    checks++; if (bus.wen_q !== 3'b000 || bus.dest_q !== 15'd0) begin errors++; $display("FAIL midreset got wen=%b dest=%h expected 000/0", bus.wen_q, bus.dest_q); end
    rst_n = 1'b1;
    $display("mid_reset: dest_q=%h wen_q=%b", bus.dest_q, bus.wen_q);
  endtask

  initial begin
    test_reset();
    test_select();
    test_shift();
    test_forward();
    test_zero_bubble();
    test_stall_flush();
    test_reserved();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regdst_pipe.md
Name: regdst_pipe

Overview:
- Parametrised successor to the EX-stage destination-register mux. Selects the write-back register from rt (ins_20_16), rd (ins_15_11) or the link register for JAL/JALR.
- Carries the selected destination and its write enable through a DEPTH-stage shift pipeline that stands in for EX/MEM, MEM/WB and later stages.
- Resolves forwarding sources for two operand addresses from that pipeline.
- Sits between decode/EX control and the forwarding mux selects in the MIPS pipeline.

Parameters:
- ADDR_W, 5, register address width.
- DEPTH, 3, number of tracked in-flight stages (1..8).
- LINK_REG, 31, register selected when reg_dst = 2'b10.
- FWD_W, $clog2(DEPTH+1), forwarding-select width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- ins_20_16  in  ADDR_W  rt field
- ins_15_11  in  ADDR_W  rd field
- reg_dst  in  2  00 = rt, 01 = rd, 10 = LINK_REG, 11 = reserved
- reg_write  in  1  instruction writes the register file
- in_valid  in  1  EX slot holds a real instruction
- stall  in  1  freeze the whole pipeline
- flush  in  1  discard the EX instruction (bubble into stage 0)
- src_a, src_b  in  ADDR_W  operand addresses of the instruction now in EX
- result  out  ADDR_W  combinational selected destination for the current EX instruction
- dest_q  out  DEPTH*ADDR_W  stage k destination at bits [k*ADDR_W +: ADDR_W]; stage 0 is youngest
- wen_q  out  DEPTH  per-stage effective write enable
- fwd_a, fwd_b  out  FWD_W  0 = no forward, k+1 = forward from stage k

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset: every dest_q field = 0 and wen_q = 0 on the first rising edge with rst_n = 0. Consequently fwd_a = fwd_b = 0 during reset. A reset mid-stream drops all in-flight entries with no drain.
- result is purely combinational:
  - reg_dst 00 -> ins_20_16
  - reg_dst 01 -> ins_15_11
  - reg_dst 10 -> LINK_REG[ADDR_W-1:0]
  - reg_dst 11 -> ins_20_16
- Effective enable for the EX instruction: eff = reg_write & in_valid & (result != 0). Writes to $0 never enter the pipeline as valid.
- Per clock edge, with rst_n = 1, in priority order:
  - flush = 1: stage 0 <= {dest 0, wen 0}. Stages 1..DEPTH-1 hold if stall = 1, otherwise shift (stage k <= stage k-1).
  - stall = 1 (no flush): all stages hold, including stage 0.
  - otherwise: stage 0 <= {result, eff}; stage k <= stage k-1. The oldest stage falls off the end.
- Latency: a destination selected in cycle n appears in stage 0 in cycle n+1 and in stage k in cycle n+1+k, provided there is no stall.
- Forwarding (combinational from registered state and src):
  - fwd_a = k+1 for the smallest k with wen_q[k] = 1 and dest_q stage k == src_a, else 0. Youngest stage wins.
  - src_a == 0 always gives 0.
  - fwd_b is identical, using src_b.
- Bubbles: a stage with wen = 0 never matches, regardless of its dest field.
- DEPTH = 1 is legal: single stage, FWD_W = 1.

Optional Feature:
- Macro: REGDST_ILLEGAL_CHK_EN.
- Defined:
  - Adds output illegal_err (1 bit), sticky.
  - Set on any edge where in_valid = 1, reg_dst = 11, stall = 0 and flush = 0.
  - Cleared only by reset.
  - The offending instruction is converted to a bubble (wen 0) in stage 0.
- Undefined: no illegal_err port; reg_dst = 11 behaves as rt with normal enable.

Test Plan:
- Reset then sel: rst_n = 0 for 2 cycles, then ins_20_16 = 1, ins_15_11 = 2, reg_dst = 00 -> result = 1; reg_dst = 01 -> result = 2; reg_dst = 10 -> result = 31. All wen_q = 0 during reset.
- Shift: issue dests 5, 6, 7 on consecutive cycles with reg_write = 1 and in_valid = 1 -> after the third edge dest_q stages 0/1/2 = 7/6/5 and wen_q = 3'b111. One more idle cycle -> stage 2 = 6.
- Forward priority: stages hold 9 (st0), 9 (st1), 4 (st2), all enabled; src_a = 9, src_b = 4 -> fwd_a = 1, fwd_b = 3. src_a = 0 -> fwd_a = 0.
- Zero/bubble: issue rd = 0 with reg_write = 1 -> wen_q[0] = 0 and src_a = 0 gives no forward. Issue in_valid = 0 -> stage 0 wen = 0.
- Stall and flush: pipeline 3/2/1. stall = 1 for 2 cycles -> unchanged. stall = 1 with flush = 1 -> stage 0 = bubble, stages 1/2 hold 2/1. flush alone -> bubble in, 2 shifts to stage 2.
- Optional (REGDST_ILLEGAL_CHK_EN): reg_dst = 11 with in_valid = 1 -> illegal_err = 1 next cycle and wen_q[0] = 0; err stays 1 until rst_n = 0.
